lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store front end sitting directly upstream of the data RAM.
- Accepts one load or store request at a time from the execute stage over a valid/ready handshake.
- For stores: drives the RAM write port with shifted data and byte strobes.
- For loads: issues the RAM read, waits out its 1-cycle registered read latency, then aligns and sign/zero-extends the returned word.
- Returns a single response (load data or store ack) to the writeback stage.

Parameters:
- AddrBusWidth, 32: byte address width on both sides.
- DataBusWidth, 32: data width; fixed at 32 for RV32 (sizes B/H/W).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1=store, 0=load.
- req_addr  in  AddrBusWidth  byte address.
- req_wdata  in  DataBusWidth  store data, right-justified.
- req_funct3  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  DataBusWidth  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3.
- mem_re  out  1  RAM read enable.
- mem_r_addr  out  AddrBusWidth  RAM read byte address, word-aligned (bits[1:0]=0).
- mem_r_data  in  DataBusWidth  RAM read data; valid the cycle after mem_re.
- mem_we  out  1  RAM write enable.
- mem_w_addr  out  AddrBusWidth  RAM write word index (byte address >> 2).
- mem_w_data  out  DataBusWidth  store data shifted to byte lane.
- mem_w_size  out  DataBusWidth  byte strobes in bits[3:0]; upper bits 0.

Behaviour:
- FSM states:
  - IDLE: req_ready=1.
  - RD_ISSUE: mem_re=1.
  - RD_WAIT: capture mem_r_data.
  - WR: mem_we=1.
  - RESP: resp_valid=1.
- All mem_* and resp_* outputs are registered or decoded from state/captured registers; there are no combinational paths from req_* to mem_* or resp_*.
- Reset (rst_n=0 at posedge): state=IDLE; every output 0 except req_ready=1; captured registers cleared. Reset mid-operation abandons the access; no mem_we is issued after reset asserts.
- Accept: req_valid & req_ready at posedge latches we, addr, wdata, funct3.
  - Error request → RESP directly.
  - Load → RD_ISSUE.
  - Store → WR.
- Errors:
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
  - Illegal funct3.
  - On error: no memory access, resp_err=1, resp_data=0.
- Load timing: RD_ISSUE (mem_re=1 for exactly 1 cycle, mem_r_addr = {addr[AW-1:2],2'b00}) → RD_WAIT (latch mem_r_data) → RESP. resp_valid first asserts 3 cycles after the accept edge.
- Load extract:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Store timing: WR (mem_we=1 for exactly 1 cycle) → RESP with resp_data=0, resp_err=0.
  - Strobes: B = 0001 << addr[1:0]; H = 0011 << addr[1:0]; W = 1111.
  - mem_w_data = req_wdata << (8*addr[1:0]).
- RESP: hold resp_valid, resp_data and resp_err stable until resp_ready=1. The handshake edge returns the FSM to IDLE, so a new request can be accepted the following cycle (no back-to-back overlap).
- resp_ready=1 while not in RESP is ignored. req_valid while req_ready=0 is ignored; the upstream holds it.
- Throughput: at most 1 access per 3 cycles for stores and 4 cycles for loads, with zero backpressure.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned H/HU/W requests are flagged with resp_err=1 as above, with no memory access.
- Undefined: no misalignment check.
  - H/HU addresses are forced to addr[0]=0; W addresses are forced to addr[1:0]=0.
  - The access proceeds normally at the forced address.
  - resp_err is set only for illegal funct3.

Test Plan:
- Reset: rst_n low 2 cycles mid-load → all outputs 0, req_ready=1, no mem_re/mem_we afterwards.
- Store byte: addr=0x0000_0103, wdata=0x0000_00A5, funct3=000 → one-cycle mem_we, mem_w_addr=0x40, mem_w_size[3:0]=1000, mem_w_data=0xA500_0000, then resp_valid with err=0.
- Load byte signed: addr=0x102, mem_r_data=0x1280_3456 → mem_r_addr=0x100, resp_data=0xFFFF_FF80 exactly 3 cycles after accept.
- Load half unsigned: addr=0x102, funct3=101, mem_r_data=0x8001_FFFF → resp_data=0x0000_8001.
- Backpressure: resp_ready held low 5 cycles → resp_valid/resp_data stable and req_ready=0 throughout; completes on the first cycle resp_ready=1.
- Misaligned word: addr=0x101, funct3=010.
  - With LSU_MISALIGN_TRAP_EN: resp_err=1, no mem_re.
  - Without it: mem_r_addr=0x100, err=0.

Source files
------------

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32 load/store front end for a 1-cycle-latency RAM; define LSU_MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses
module lsu_mem_port #(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AddrBusWidth-1:0] req_addr,
  input  logic [DataBusWidth-1:0] req_wdata,
  input  logic [2:0]              req_funct3,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DataBusWidth-1:0] resp_data,
  output logic                    resp_err,
  output logic                    mem_re,
  output logic [AddrBusWidth-1:0] mem_r_addr,
  input  logic [DataBusWidth-1:0] mem_r_data,
  output logic                    mem_we,
  output logic [AddrBusWidth-1:0] mem_w_addr,
  output logic [DataBusWidth-1:0] mem_w_data,
  output logic [DataBusWidth-1:0] mem_w_size
);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, RESP} state_t;
  state_t state, state_nx;
  logic [AddrBusWidth-1:0] addr_q, addr_in;
  logic [DataBusWidth-1:0] wdata_q, rdata_q, sh, ld_val;
  logic [2:0] f3_q;
  logic err_q, err_in, legal, is_h, is_w, misal, accept;
  logic [3:0] strb;
  always_comb begin
    legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    is_h = req_funct3[1:0] == 2'b01;
    is_w = req_funct3 == 3'b010;
    misal = (is_h & req_addr[0]) | (is_w & |req_addr[1:0]);
    accept = req_valid & (state == IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
    err_in = ~legal | misal;
    addr_in = req_addr;
`else
    err_in = ~legal;
    addr_in = {req_addr[AddrBusWidth-1:2], req_addr[1] & ~is_w, req_addr[0] & ~is_h & ~is_w};
`endif
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = !accept ? IDLE : err_in ? RESP : req_we ? WR : RD_ISSUE;
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  state_nx = RESP;
      WR:       state_nx = RESP;
      RESP:     state_nx = resp_ready ? IDLE : RESP;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    sh = mem_r_data >> {addr_q[1:0], 3'b000};
    ld_val = f3_q == 3'b000 ? {{(DataBusWidth-8){sh[7]}}, sh[7:0]} :
             f3_q == 3'b001 ? {{(DataBusWidth-16){sh[15]}}, sh[15:0]} :
             f3_q == 3'b100 ? {{(DataBusWidth-8){1'b0}}, sh[7:0]} :
             f3_q == 3'b101 ? {{(DataBusWidth-16){1'b0}}, sh[15:0]} : mem_r_data;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      addr_q <= '0;
      wdata_q <= '0;
      f3_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      addr_q <= addr_in;
      wdata_q <= req_wdata;
      f3_q <= req_funct3;
      err_q <= err_in;
      rdata_q <= '0;
    end else if (state == RD_WAIT) rdata_q <= ld_val;
  always_comb begin
    req_ready = state == IDLE;
    mem_re = state == RD_ISSUE;
    mem_we = state == WR;
    resp_valid = state == RESP;
    strb = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
           f3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
    mem_r_addr = mem_re ? {addr_q[AddrBusWidth-1:2], 2'b00} : '0;
    mem_w_addr = mem_we ? addr_q >> 2 : '0;
    mem_w_data = mem_we ? wdata_q << {addr_q[1:0], 3'b000} : '0;
    mem_w_size = mem_we ? DataBusWidth'(strb) : '0;
    resp_data = resp_valid ? rdata_q : '0;
    resp_err = resp_valid & err_q;
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed table, reset/backpressure sequences and random traffic against a byte-level memory model
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, mem_re, mem_we;
  logic [31:0] req_addr, req_wdata, resp_data, mem_r_addr, mem_r_data, mem_w_addr, mem_w_data, mem_w_size;
  logic [2:0] req_funct3;
  logic pre_en;
  logic [7:0] pre_idx;
  logic [31:0] pre_val;
  logic [31:0] ram [0:255];
  logic [7:0] ref_mem [0:1023];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  lsu_mem_port dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err), .mem_re(mem_re),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data), .mem_we(mem_we), .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data), .mem_w_size(mem_w_size)
  );
  // RAM with registered read and byte-strobed write
  always @(posedge clk) begin
    if (pre_en) ram[pre_idx] <= pre_val;
    if (mem_re) mem_r_data <= ram[mem_r_addr[9:2]];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_w_size[b]) ram[mem_w_addr[7:0]][8*b +: 8] <= mem_w_data[8*b +: 8];
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
  typedef struct {
    logic pl, we;
    logic [31:0] addr, wdata;
    logic [2:0] f3;
    logic [31:0] pre, d;
    logic e;
    int lat, nre, nwe;
    logic [31:0] maddr, mdata, strb;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic pl, we, input logic [31:0] addr, wdata, input logic [2:0] f3,
                     input logic [31:0] pre, d, input logic e, input int lat, nre, nwe,
                     input logic [31:0] maddr, mdata, strb);
    vec_t v;
    v.pl = pl; v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.pre = pre; v.d = d; v.e = e;
    v.lat = lat; v.nre = nre; v.nwe = nwe; v.maddr = maddr; v.mdata = mdata; v.strb = strb;
    tv.push_back(v);
  endtask
  task automatic chk(input string nm, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    chk({nm, "_ctl"}, 32'({mem_re, mem_we, resp_valid, resp_err}), 32'd0);
    chk({nm, "_bus"}, mem_r_addr | mem_w_addr | mem_w_data | mem_w_size | resp_data, 32'd0);
  endtask
  task automatic preload(input logic [31:0] addr, val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = addr[9:2]; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask
  task automatic do_req(input string nm, input logic we, input logic [31:0] addr, wdata,
                        input logic [2:0] f3, input int stall, input logic [31:0] ed,
                        input logic ee, input int el, output int nre, nwe,
                        output logic [31:0] maddr, mdata, strb);
    bit seen = 0;
    int lat = 0;
    nre = 0; nwe = 0; maddr = 0; mdata = 0; strb = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    resp_ready = stall == 0;
    @(posedge clk);
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_re) begin nre++; maddr = mem_r_addr; end
      if (mem_we) begin nwe++; maddr = mem_w_addr; mdata = mem_w_data; strb = mem_w_size; end
      if (resp_valid) begin seen = 1; lat = k; end
    end
    chk({nm, "_lat"}, 32'(lat), 32'(el));
    if (seen) begin
      chk({nm, "_data"}, resp_data, ed);
      chk({nm, "_err"}, 32'(resp_err), 32'(ee));
      repeat (stall) begin
        @(negedge clk);
        chk({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
        chk({nm, "_hold_data"}, resp_data, ed);
        chk({nm, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({nm, "_done"}, 32'({resp_valid, req_ready}), 32'd1);
    end
  endtask
  // Byte-addressed view of memory: the access is just `size` consecutive little-endian bytes
  task automatic model(input logic we, input logic [31:0] addr, wdata, input logic [2:0] f3,
                       output logic [31:0] d, output logic e);
    int size = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    logic legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] eff = addr - 32'(addr % size);
    logic [9:0] base = eff[9:0];
`ifdef LSU_MISALIGN_TRAP_EN
    e = !legal || (addr % size) != 0;
`else
    e = !legal;
`endif
    d = 0;
    if (!e && we)
      for (int i = 0; i < size; i++) ref_mem[base + 10'(i)] = wdata[8*i +: 8];
    else if (!e) begin
      for (int i = 0; i < size; i++) d = d | (32'(ref_mem[base + 10'(i)]) << (8*i));
      if (!f3[2] && size < 4 && d[8*size-1]) d = d | (32'hFFFF_FFFF << (8*size));
    end
  endtask
  initial begin
    int nre, nwe, bad;
    logic [31:0] maddr, mdata, strb, d;
    logic e, we;
    logic [31:0] addr, wdata;
    logic [2:0] f3;
    int stall;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
    resp_ready = 1'b0; pre_en = 1'b0; pre_idx = 0; pre_val = 0;
    repeat (2) @(posedge clk);
    #1 chk_idle("reset");
    @(negedge clk) rst_n = 1'b1;
    add(0, 1, 32'h103, 32'hA5, 3'b000, 0, 0, 0, 2, 0, 1, 32'h40, 32'hA500_0000, 32'h8);
    add(1, 0, 32'h102, 0, 3'b000, 32'h1280_3456, 32'hFFFF_FF80, 0, 3, 1, 0, 32'h100, 0, 0);
    add(1, 0, 32'h102, 0, 3'b101, 32'h8001_FFFF, 32'h0000_8001, 0, 3, 1, 0, 32'h100, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    add(1, 0, 32'h101, 0, 3'b010, 32'hDEAD_BEEF, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 32'h203, 32'hBEEF, 3'b001, 0, 0, 1, 1, 0, 0, 0, 0, 0);
`else
    add(1, 0, 32'h101, 0, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 3, 1, 0, 32'h100, 0, 0);
    add(0, 1, 32'h203, 32'hBEEF, 3'b001, 0, 0, 0, 2, 0, 1, 32'h80, 32'hBEEF_0000, 32'hC);
`endif
    add(1, 0, 32'h200, 0, 3'b011, 32'h1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 32'h202, 32'h1234_ABCD, 3'b001, 0, 0, 0, 2, 0, 1, 32'h80, 32'hABCD_0000, 32'hC);
    add(1, 0, 32'h200, 0, 3'b001, 32'h0000_F00D, 32'hFFFF_F00D, 0, 3, 1, 0, 32'h200, 0, 0);
    add(0, 1, 32'h204, 32'hCAFE_BABE, 3'b010, 0, 0, 0, 2, 0, 1, 32'h81, 32'hCAFE_BABE, 32'hF);
    add(0, 0, 32'h204, 0, 3'b010, 0, 32'hCAFE_BABE, 0, 3, 1, 0, 32'h204, 0, 0);
    add(1, 0, 32'h301, 0, 3'b100, 32'h0000_9A00, 32'h0000_009A, 0, 3, 1, 0, 32'h300, 0, 0);
    add(0, 1, 32'h300, 32'hFF, 3'b111, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    foreach (tv[i]) begin
      if (tv[i].pl) preload(tv[i].addr, tv[i].pre);
      do_req($sformatf("vec%0d", i), tv[i].we, tv[i].addr, tv[i].wdata, tv[i].f3, 0, tv[i].d,
             tv[i].e, tv[i].lat, nre, nwe, maddr, mdata, strb);
      chk($sformatf("vec%0d_nre", i), 32'(nre), 32'(tv[i].nre));
      chk($sformatf("vec%0d_nwe", i), 32'(nwe), 32'(tv[i].nwe));
      chk($sformatf("vec%0d_maddr", i), maddr, tv[i].maddr);
      chk($sformatf("vec%0d_mdata", i), mdata, tv[i].mdata);
      chk($sformatf("vec%0d_strb", i), strb, tv[i].strb);
    end
    do_req("backpressure", 0, 32'h204, 0, 3'b010, 5, 32'hCAFE_BABE, 0, 3, nre, nwe, maddr, mdata, strb);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_funct3 = 3'b010; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_idle("midload_reset");
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_re || mem_we || resp_valid || !req_ready) bad++;
    end
    chk("post_reset_quiet", 32'(bad), 32'd0);
    for (int w = 0; w < 256; w++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_idx = 8'(w); pre_val = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = pre_val[8*b +: 8];
    end
    @(negedge clk) pre_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      addr = $urandom;
      wdata = $urandom;
      f3 = 3'($urandom_range(0, 7));
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      model(we, addr, wdata, f3, d, e);
      do_req($sformatf("rnd%0d", i), we, addr, wdata, f3, stall, d, e, e ? 1 : we ? 2 : 3,
             nre, nwe, maddr, mdata, strb);
      chk($sformatf("rnd%0d_nre", i), 32'(nre), 32'(!e && !we));
      chk($sformatf("rnd%0d_nwe", i), 32'(nwe), 32'(!e && we));
      if (!e) chk($sformatf("rnd%0d_maddr", i), maddr, we ? addr >> 2 : addr & 32'hFFFF_FFFC);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
